// File: rtl/i2c_target_model.sv
// I2C target: oversamples SCL/SDA, acknowledges one 7-bit address, serves a byte register file with auto-incrementing pointer.
// sda_o updates one clk after a synchronized SCL fall; the target never stretches SCL.
module i2c_target_model #(
    parameter logic [6:0]  TargetAddr = 7'h50,
    parameter int unsigned MemDepth   = 16,
    parameter int unsigned SyncStages = 2,
    localparam int unsigned AW        = $clog2(MemDepth)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_o,
    output logic          busy_o,
    output logic          rx_valid_o,
    output logic [7:0]    rx_data_o,
    output logic [AW-1:0] rx_addr_o
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
    } state_e;

    state_e                state_q, state_d;
    logic [SyncStages-1:0] scl_sync, sda_sync;
    logic                  scl_s, sda_s, scl_q, sda_q;
    logic                  scl_rise, scl_fall, start_det, stop_det;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shreg_q, shreg_d, txb_q, txb_d, byte_in;
    logic                  ack_q, ack_d, rw_q, rw_d;
    logic [AW-1:0]         ptr_q, ptr_d;
    logic                  sda_d, busy_d, rx_vld_d, mem_we;
    logic [7:0]            rx_dat_d;
    logic [AW-1:0]         rx_adr_d;
    logic [7:0]            mem [MemDepth];

    assign scl_s     = scl_sync[SyncStages-1];
    assign sda_s     = sda_sync[SyncStages-1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = scl_s & ~sda_s & sda_q;
    assign stop_det  = scl_s & sda_s & ~sda_q;
    assign byte_in   = {shreg_q[6:0], sda_s};

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        txb_d     = txb_q;
        ack_d     = ack_q;
        rw_d      = rw_q;
        ptr_d     = ptr_q;
        sda_d     = sda_o;
        busy_d    = busy_o;
        rx_vld_d  = 1'b0;
        rx_dat_d  = rx_data_o;
        rx_adr_d  = rx_addr_o;
        mem_we    = 1'b0;
        if (stop_det) begin
            state_d = IDLE;
            sda_d   = 1'b1;
            busy_d  = 1'b0;
        end else if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_d     = 1'b1;
        end else if (scl_rise) begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    shreg_d   = byte_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        ack_d = 1'b0;
                        if (state_q == ADDR) begin
                            if (byte_in[7:1] == TargetAddr) begin
                                state_d = ADDR_ACK;
                                busy_d  = 1'b1;
                                rw_d    = byte_in[0];
                            end else begin
                                state_d = WAIT_STOP;
                                busy_d  = 1'b0;
                            end
                        end else if (state_q == PTR) begin
                            ptr_d   = byte_in[AW-1:0];
                            state_d = PTR_ACK;
                        end else begin
                            mem_we   = 1'b1;
                            rx_vld_d = 1'b1;
                            rx_dat_d = byte_in;
                            rx_adr_d = ptr_q;
                            ptr_d    = ptr_q + AW'(1);
                            state_d  = WDATA_ACK;
                        end
                    end
                end
                RDATA_ACK: begin
                    if (sda_s) state_d = WAIT_STOP;
                    else       ack_d   = 1'b1;
                end
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state_q)
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    // first fall starts driving ACK, second fall ends the ACK clock
                    if (!ack_q) begin
                        sda_d = 1'b0;
                        ack_d = 1'b1;
                    end else begin
                        bit_cnt_d = '0;
                        if (state_q == ADDR_ACK && rw_q) begin
                            txb_d     = mem[ptr_q];
                            sda_d     = mem[ptr_q][7];
                            bit_cnt_d = 3'd1;
                            state_d   = RDATA;
                        end else begin
                            sda_d   = 1'b1;
                            state_d = (state_q == ADDR_ACK) ? PTR : WDATA;
                        end
                    end
                end
                RDATA: begin
                    if (bit_cnt_q == 3'd0) begin
                        sda_d   = 1'b1;
                        ack_d   = 1'b0;
                        state_d = RDATA_ACK;
                    end else begin
                        sda_d     = txb_q[~bit_cnt_q];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) ptr_d = ptr_q + AW'(1);
                    end
                end
                RDATA_ACK: begin
                    if (ack_q) begin
                        txb_d     = mem[ptr_q];
                        sda_d     = mem[ptr_q][7];
                        bit_cnt_d = 3'd1;
                        state_d   = RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_sync   <= '1;
            sda_sync   <= '1;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            txb_q      <= '0;
            ack_q      <= 1'b0;
            rw_q       <= 1'b0;
            ptr_q      <= '0;
            sda_o      <= 1'b1;
            busy_o     <= 1'b0;
            rx_valid_o <= 1'b0;
            rx_data_o  <= '0;
            rx_addr_o  <= '0;
            for (int i = 0; i < int'(MemDepth); i++) mem[i] <= '0;
        end else begin
            scl_sync   <= {scl_sync[SyncStages-2:0], scl_i};
            sda_sync   <= {sda_sync[SyncStages-2:0], sda_i};
            scl_q      <= scl_s;
            sda_q      <= sda_s;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            txb_q      <= txb_d;
            ack_q      <= ack_d;
            rw_q       <= rw_d;
            ptr_q      <= ptr_d;
            sda_o      <= sda_d;
            busy_o     <= busy_d;
            rx_valid_o <= rx_vld_d;
            rx_data_o  <= rx_dat_d;
            rx_addr_o  <= rx_adr_d;
            if (mem_we) mem[ptr_q] <= byte_in;
        end
    end
endmodule

// File: tb/tb_i2c_target_model.sv
// Bench for i2c_target_model: bit-banged I2C controller plus a byte-level memory/pointer reference model.
module tb_i2c_target_model;
    localparam int Q = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda;
    logic       sda_o, busy, rx_valid;
    logic [7:0] rx_data;
    logic [3:0] rx_addr;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  m_mem [16];
    int          m_ptr = 0;
    logic [11:0] exp_rx [$];
    logic [11:0] got_rx [$];
    logic [7:0]  wb [8];
    int          sda_low_cnt = 0;
    bit          mon_en = 1'b0;

    assign sda = sda_m & sda_o;

    always #5 clk = ~clk;

    i2c_target_model #(.TargetAddr(7'h50), .MemDepth(16), .SyncStages(2)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .scl_i      (scl),
        .sda_i      (sda),
        .sda_o      (sda_o),
        .busy_o     (busy),
        .rx_valid_o (rx_valid),
        .rx_data_o  (rx_data),
        .rx_addr_o  (rx_addr)
    );

    always @(negedge clk) begin
        if (rx_valid) got_rx.push_back({rx_addr, rx_data});
        if (mon_en && !sda_o) sda_low_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic bus_start;
        sda_m = 1'b1; tick(Q);
        scl = 1'b1;   tick(Q);
        sda_m = 1'b0; tick(Q);
        scl = 1'b0;   tick(Q);
    endtask

    task automatic bus_stop;
        sda_m = 1'b0; tick(Q);
        scl = 1'b1;   tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic clk_bit(input logic b, output logic s);
        sda_m = b;  tick(Q);
        scl = 1'b1; tick(Q);
        @(negedge clk);
        s = sda;    tick(Q);
        scl = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input bit ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            d[i] = s;
        end
        clk_bit(~ack, s);
    endtask

    // controller write: first data byte is the pointer, the rest go to memory
    task automatic wr_xact(input logic [7:0] a, input int n, input bit stop);
        logic ack;
        bit   match;
        match = (a[7:1] == 7'h50) && !a[0];
        bus_start;
        write_byte(a, ack);
        check("wr_addr_ack", ack, match);
        if (match) check("busy_on", busy, 1);
        for (int i = 0; i < n; i++) begin
            write_byte(wb[i], ack);
            check("wr_data_ack", ack, match);
            if (match) begin
                if (i == 0) m_ptr = int'(wb[i]) % 16;
                else begin
                    exp_rx.push_back({4'(m_ptr), wb[i]});
                    m_mem[m_ptr] = wb[i];
                    m_ptr = (m_ptr + 1) % 16;
                end
            end
        end
        if (stop) begin
            bus_stop;
            check("busy_off", busy, 0);
        end
    endtask

    task automatic rd_xact(input int n);
        logic       ack;
        logic [7:0] d;
        bus_start;
        write_byte(8'hA1, ack);
        check("rd_addr_ack", ack, 1);
        for (int i = 0; i < n; i++) begin
            read_byte(i < n - 1, d);
            check("rd_data", d, m_mem[m_ptr]);
            m_ptr = (m_ptr + 1) % 16;
        end
        bus_stop;
        check("busy_off", busy, 0);
    endtask

    task automatic check_rx;
        logic [11:0] e, g;
        check("rx_count", got_rx.size(), exp_rx.size());
        while (exp_rx.size() > 0) begin
            e = exp_rx.pop_front();
            g = 12'hxxx;
            if (got_rx.size() > 0) g = got_rx.pop_front();
            check("rx_addr_data", g, e);
        end
        got_rx.delete();
    endtask

    initial begin
        logic ack, s;
        int   base, kind, n;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;

        tick(3);
        @(negedge clk);
        check("rst_sda", sda_o, 1);
        check("rst_busy", busy, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_addr", rx_addr, 0);
        rst_n = 1'b1;
        tick(Q);

        // basic write, then pointer set + repeated START read
        wb[0] = 8'h03; wb[1] = 8'hA5; wb[2] = 8'h5A;
        wr_xact(8'hA0, 3, 1);
        check_rx;
        wb[0] = 8'h03;
        wr_xact(8'hA0, 1, 0);
        rd_xact(2);
        rd_xact(1);

        // wrong address: line never pulled low by the target
        base = sda_low_cnt;
        mon_en = 1'b1;
        wb[0] = 8'h03; wb[1] = 8'h77;
        wr_xact(8'hA2, 2, 0);
        check("nomatch_busy", busy, 0);
        bus_stop;
        mon_en = 1'b0;
        check("nomatch_sda_low", sda_low_cnt - base, 0);
        check_rx;

        // pointer wrap and pointer high bits ignored
        wb[0] = 8'h0F; wb[1] = 8'h11; wb[2] = 8'h22;
        wr_xact(8'hA0, 3, 1);
        wb[0] = 8'h1F; wb[1] = 8'h33;
        wr_xact(8'hA0, 2, 1);
        check_rx;
        wb[0] = 8'h0F;
        wr_xact(8'hA0, 1, 0);
        rd_xact(3);

        // STOP after 4 data bits discards the partial byte
        wb[0] = 8'h07;
        wr_xact(8'hA0, 1, 0);
        for (int i = 0; i < 4; i++) clk_bit(1'($urandom_range(0, 1)), s);
        bus_stop;
        check("partial_busy", busy, 0);
        check_rx;
        wb[0] = 8'h07; wb[1] = 8'h3C;
        wr_xact(8'hA0, 2, 1);
        check_rx;
        wb[0] = 8'h07;
        wr_xact(8'hA0, 1, 0);
        rd_xact(2);

        // reset while the target drives a 0 read bit
        wb[0] = 8'h09; wb[1] = 8'h12;
        wr_xact(8'hA0, 2, 1);
        check_rx;
        wb[0] = 8'h09;
        wr_xact(8'hA0, 1, 0);
        bus_start;
        write_byte(8'hA1, ack);
        check("rst_rd_ack", ack, 1);
        @(negedge clk);
        check("rd_bit_driven", sda_o, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_sda", sda_o, 1);
        check("midrst_busy", busy, 0);
        scl = 1'b1; sda_m = 1'b1;
        tick(3);
        @(negedge clk);
        rst_n = 1'b1;
        tick(Q);
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_ptr = 0;
        got_rx.delete();
        rd_xact(2);
        wb[0] = 8'h09;
        wr_xact(8'hA0, 1, 0);
        rd_xact(1);

        // randomized mix of writes and reads
        for (int t = 0; t < 16; t++) begin
            kind = $urandom_range(0, 3);
            n = $urandom_range(1, 4);
            if (kind <= 1) begin
                for (int i = 0; i < 8; i++) wb[i] = 8'($urandom);
                if ($urandom_range(0, 5) == 0) wr_xact({7'($urandom), 1'b0}, n, 1);
                else                           wr_xact(8'hA0, n, 1);
            end else if (kind == 2) begin
                wb[0] = 8'($urandom);
                wr_xact(8'hA0, 1, 0);
                rd_xact(n);
            end else begin
                rd_xact(n);
            end
            check_rx;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
